// File: rtl/freq_counter_multi_if.sv
// Control and readback bundle of the multi-channel frequency counter.
// master = register/control side, slave = counter core.
interface freq_counter_multi_if #(
  parameter int NUM_CH     = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int GATE_WIDTH = 26,
  parameter int SEL_WIDTH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [GATE_WIDTH-1:0]       gate_cycles_i;
  logic                        mode_i;
  logic                        enable_i;
  logic                        start_i;
  logic [SEL_WIDTH-1:0]        ch_sel_i;
  logic [CNT_WIDTH-1:0]        freq_o;
  logic [NUM_CH*CNT_WIDTH-1:0] results_o;
  logic [NUM_CH-1:0]           overflow_o;
  logic                        valid_o;
  logic                        busy_o;

  modport master (
    output gate_cycles_i, mode_i, enable_i, start_i, ch_sel_i,
    input  freq_o, results_o, overflow_o, valid_o, busy_o
  );

  modport slave (
    input  gate_cycles_i, mode_i, enable_i, start_i, ch_sel_i,
    output freq_o, results_o, overflow_o, valid_o, busy_o
  );
endinterface

// File: rtl/freq_counter_multi.sv
// Multi-channel gated rising-edge counter: synchronised inputs, programmable
// gate, continuous or single-shot windows, saturating latched results.
module freq_counter_multi #(
  parameter int NUM_CH     = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int GATE_WIDTH = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   sig_i,
  freq_counter_multi_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                state_q, state_d;
  logic [GATE_WIDTH-1:0] gate_left_q, gate_left_d, gate_init;
  logic                  mode_q, mode_d;
  logic                  valid_q, valid_d;
  logic [NUM_CH-1:0]     sync1_q, sync2_q, prev_q, edge_w;
  logic                  clear_w, count_w, load_w;
  logic                  start_go, abort_w;
  logic [CNT_WIDTH-1:0]  res_arr [NUM_CH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_w = sync2_q & ~prev_q;

  // A zero gate length behaves as a one-cycle window.
  assign gate_init = (bus.gate_cycles_i == '0) ? '0 : bus.gate_cycles_i - GATE_WIDTH'(1);
  assign start_go  = bus.mode_i ? bus.start_i : bus.enable_i;
  assign abort_w   = (state_q == ST_RUN) && !mode_q && !bus.enable_i && (gate_left_q != '0);

  always_comb begin
    state_d     = state_q;
    gate_left_d = gate_left_q;
    mode_d      = mode_q;
    valid_d     = 1'b0;
    clear_w     = 1'b0;
    count_w     = 1'b0;
    load_w      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clear_w = 1'b1;
        if (start_go) begin
          state_d     = ST_RUN;
          gate_left_d = gate_init;
          mode_d      = bus.mode_i;
        end
      end
      ST_RUN: begin
        if (abort_w) begin
          state_d = ST_IDLE;
          clear_w = 1'b1;
        end else if (gate_left_q != '0) begin
          count_w     = 1'b1;
          gate_left_d = gate_left_q - GATE_WIDTH'(1);
        end else begin
          // Final cycle: latch results and, in continuous mode, open the
          // next window back-to-back so no edge falls between windows.
          load_w  = 1'b1;
          valid_d = 1'b1;
          clear_w = 1'b1;
          if (!mode_q && bus.enable_i) begin
            gate_left_d = gate_init;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gate_left_q <= '0;
      mode_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_left_q <= gate_left_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d, sum_w, res_q;
      logic                 ovf_q, ovf_d, hit_w, res_ovf_q;

      assign hit_w = edge_w[gi] && (cnt_q == CNT_MAX);
      assign sum_w = (edge_w[gi] && !hit_w) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

      always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_w) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (count_w) begin
          cnt_d = sum_w;
          ovf_d = ovf_q | hit_w;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt_q     <= '0;
          ovf_q     <= 1'b0;
          res_q     <= '0;
          res_ovf_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
          if (load_w) begin
            res_q     <= sum_w;
            res_ovf_q <= ovf_q | hit_w;
          end
        end
      end

      assign res_arr[gi]                              = res_q;
      assign bus.results_o[gi*CNT_WIDTH +: CNT_WIDTH] = res_q;
      assign bus.overflow_o[gi]                       = res_ovf_q;
    end
  endgenerate

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    bus.freq_o = res_arr[0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (int'(bus.ch_sel_i) == k) bus.freq_o = res_arr[k];
    end
  end

  assign bus.busy_o  = (state_q == ST_RUN);
  assign bus.valid_o = valid_q;
endmodule

// File: tb/tb_freq_counter_multi.sv
// Randomised scoreboard bench for freq_counter_multi: windows are queued when
// issued and a negedge monitor checks each valid_o against an edge-log model.
module tb_freq_counter_multi;
  localparam int NUM_CH     = 3;
  localparam int CNT_WIDTH  = 8;
  localparam int GATE_WIDTH = 12;
  localparam int SEL_WIDTH  = 2;
  localparam int CMAX       = (1 << CNT_WIDTH) - 1;
  localparam int RW         = NUM_CH * CNT_WIDTH;
  localparam int MAXC       = 60000;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_CH-1:0] sig     = '0;
  logic              rst_at_edge = 1'b1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_win = 0;

  int gen_kind [NUM_CH];
  int gen_half [NUM_CH];
  int gen_cnt  [NUM_CH];
  bit edge_map [NUM_CH][MAXC];

  int q_vcyc[$];
  int q_start[$];
  int q_len[$];

  logic [RW-1:0]     last_res = '0;
  logic [NUM_CH-1:0] last_ovf = '0;

  freq_counter_multi_if #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .GATE_WIDTH(GATE_WIDTH), .SEL_WIDTH(SEL_WIDTH)
  ) bus ();

  freq_counter_multi #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .GATE_WIDTH(GATE_WIDTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sig_i(sig),
    .bus(bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !reset_n;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Signal generators: kind 0 = held low, 1 = square wave of half-period
  // gen_half, 2 = random level each cycle. A driven rise in cycle c is seen
  // by the counter as an edge in cycle c+2.
  always @(posedge clk) begin
    logic nv;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      nv = sig[c];
      case (gen_kind[c])
        1: begin
          gen_cnt[c]++;
          if (gen_cnt[c] >= gen_half[c]) begin
            gen_cnt[c] = 0;
            nv = ~sig[c];
          end
        end
        2: nv = 1'($urandom_range(0, 1));
        default: nv = 1'b0;
      endcase
      if (nv && !sig[c] && (cyc + 2 < MAXC)) edge_map[c][cyc+2] = 1'b1;
      sig[c] = nv;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [RW-1:0]     er;
    logic [NUM_CH-1:0] eo;
    int vc, s, g, n;
    if (cyc > 0) begin
      if (rst_at_edge) begin
        last_res = '0;
        last_ovf = '0;
        chk("reset_results", 64'(bus.results_o), 64'(0));
        chk("reset_overflow", 64'(bus.overflow_o), 64'(0));
        chk("reset_valid", 64'(bus.valid_o), 64'(0));
        chk("reset_busy", 64'(bus.busy_o), 64'(0));
        chk("reset_freq", 64'(bus.freq_o), 64'(0));
      end else if (bus.valid_o) begin
        n_checks++;
        if (q_vcyc.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: valid_o=1 with no window pending (cycle %0d)", cyc);
        end else begin
          vc = q_vcyc.pop_front();
          s  = q_start.pop_front();
          g  = q_len.pop_front();
          chk("valid_cycle", 64'(cyc), 64'(vc));
          er = '0;
          eo = '0;
          for (int c = 0; c < NUM_CH; c++) begin
            n = 0;
            for (int t = s + 1; t <= s + g; t++) if (edge_map[c][t]) n++;
            er[c*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'((n > CMAX) ? CMAX : n);
            eo[c] = (n > CMAX);
          end
          chk("results", 64'(bus.results_o), 64'(er));
          chk("overflow", 64'(bus.overflow_o), 64'(eo));
          last_res = er;
          last_ovf = eo;
          n_win++;
          $display("window %0d cycle %0d G=%0d results=%h overflow=%b", n_win, cyc, g,
                   bus.results_o, bus.overflow_o);
        end
      end else begin
        chk("results_hold", 64'(bus.results_o), 64'(last_res));
        chk("overflow_hold", 64'(bus.overflow_o), 64'(last_ovf));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_gen(input int c, input int kind, input int half);
    gen_kind[c] = kind;
    gen_half[c] = half;
    gen_cnt[c]  = 0;
  endtask

  task automatic single(input int g);
    int s, ge, busy_n;
    step(1);
    s  = cyc;
    ge = (g == 0) ? 1 : g;
    bus.mode_i        = 1'b1;
    bus.gate_cycles_i = GATE_WIDTH'(g);
    bus.start_i       = 1'b1;
    q_vcyc.push_back(s + ge + 1);
    q_start.push_back(s);
    q_len.push_back(ge);
    busy_n = 0;
    for (int k = 1; k <= ge + 2; k++) begin
      step(1);
      bus.start_i = (ge >= 4 && k == 2);
      if (k == 3) bus.gate_cycles_i = GATE_WIDTH'($urandom_range(1, 50));
      if (bus.busy_o) busy_n++;
    end
    chk("busy_cycles", 64'(busy_n), 64'(ge));
    step(1);
  endtask

  task automatic cont(input int g, input int nwin);
    int s;
    step(1);
    s = cyc;
    bus.mode_i        = 1'b0;
    bus.gate_cycles_i = GATE_WIDTH'(g);
    bus.enable_i      = 1'b1;
    for (int k = 0; k < nwin; k++) begin
      q_vcyc.push_back(s + (k + 1) * g + 1);
      q_start.push_back(s + k * g);
      q_len.push_back(g);
    end
    step(1);
    chk("cont_busy_start", 64'(bus.busy_o), 64'(1));
    step(nwin * g);
    bus.enable_i = 1'b0;
    step(1);
    chk("cont_busy_stop", 64'(bus.busy_o), 64'(0));
    step(2);
  endtask

  task automatic abort_test(input int g, input int at);
    step(1);
    bus.mode_i        = 1'b0;
    bus.gate_cycles_i = GATE_WIDTH'(g);
    bus.enable_i      = 1'b1;
    step(at);
    bus.enable_i = 1'b0;
    step(1);
    chk("abort_busy", 64'(bus.busy_o), 64'(0));
    chk("abort_results", 64'(bus.results_o), 64'(last_res));
    chk("abort_overflow", 64'(bus.overflow_o), 64'(last_ovf));
    step(g);
  endtask

  task automatic reset_mid(input int g, input int at);
    step(1);
    bus.mode_i        = 1'b0;
    bus.gate_cycles_i = GATE_WIDTH'(g);
    bus.enable_i      = 1'b1;
    step(at);
    chk("pre_reset_busy", 64'(bus.busy_o), 64'(1));
    reset_n      = 1'b0;
    bus.enable_i = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_valid", 64'(bus.valid_o), 64'(0));
    chk("rst_results", 64'(bus.results_o), 64'(0));
    chk("rst_freq", 64'(bus.freq_o), 64'(0));
    step(3);
  endtask

  task automatic sel_sweep();
    logic [RW-1:0] r;
    int idx;
    for (int sel = 0; sel < 4; sel++) begin
      bus.ch_sel_i = SEL_WIDTH'(sel);
      #1;
      idx = (sel < NUM_CH) ? sel : 0;
      r   = last_res;
      chk("freq_sel", 64'(bus.freq_o), 64'(r[idx*CNT_WIDTH +: CNT_WIDTH]));
    end
  endtask

  initial begin
    #(20 * MAXC);
    $display("FAIL watchdog: simulation exceeded cycle budget (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.gate_cycles_i = '0;
    bus.mode_i        = 1'b0;
    bus.enable_i      = 1'b0;
    bus.start_i       = 1'b0;
    bus.ch_sel_i      = '0;
    for (int c = 0; c < NUM_CH; c++) set_gen(c, 0, 1);
    step(3);
    reset_n = 1'b1;
    step(2);

    // Continuous G=1000: ch0 period 8, ch1 idle, ch2 random.
    set_gen(0, 1, 4);
    set_gen(1, 0, 1);
    set_gen(2, 2, 1);
    cont(1000, 3);
    sel_sweep();

    // Single-shot with G=0 (acts as 1) and a short window with ignored start.
    set_gen(0, 1, 1);
    single(0);
    single(0);
    single(7);
    sel_sweep();

    // Saturation, then a quiet window clearing the flag.
    set_gen(0, 1, 2);
    set_gen(1, 2, 1);
    set_gen(2, 1, 1);
    single(1100);
    sel_sweep();
    set_gen(0, 0, 1);
    single(100);

    // Back-to-back windows with ch0 period 10.
    set_gen(0, 1, 5);
    cont(50, 5);

    // Abort mid-window, then reset mid-window with inputs quiet.
    abort_test(100, 30);
    for (int c = 0; c < NUM_CH; c++) set_gen(c, 0, 1);
    step(6);
    reset_mid(100, 40);

    for (int it = 0; it < 12; it++) begin
      for (int c = 0; c < NUM_CH; c++)
        set_gen(c, int'($urandom_range(0, 2)), int'($urandom_range(1, 6)));
      if ($urandom_range(0, 1) == 1) single(int'($urandom_range(0, 80)));
      else cont(int'($urandom_range(2, 40)), int'($urandom_range(1, 3)));
      if (it % 4 == 3) sel_sweep();
    end

    step(5);
    chk("scoreboard_empty", 64'(q_vcyc.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
